uart_rx_fifo: RTL

//  Downstream stage of the UART receiver: takes the receiver's byte-complete strobe and data byte,

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_sync_edge.sv | 31 +++
 rtl/uart_rx_fifo.sv | 92 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART receive path
package uart_pkg;

   typedef logic [7:0] byte_t;

   localparam int UART_RX_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_sync_edge.sv
// rtl/uart_sync_edge.sv - multi-flop level synchroniser with rise/fall detection
module uart_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_100MHz,
   input  logic rst,
   input  logic level,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] stages;
   logic                   d_q;

   // Shift the asynchronous level through the synchroniser chain, then keep one cycle of history.
   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         stages <= '0;
         d_q    <= 1'b0;
      end else begin
         stages <= {stages[SYNC_STAGES-2:0], level};
         d_q    <= stages[SYNC_STAGES-1];
      end
   end

   assign sync = stages[SYNC_STAGES-1];
   assign rise = sync & ~d_q;
   assign fall = ~sync & d_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - rx byte capture into the system domain with a FWFT buffer
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH       = UART_RX_FIFO_DEPTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk_100MHz,
   input  logic                       rst,
   input  logic                       rx_done,
   input  byte_t                      rx_data,
   input  logic                       m_ready,
   input  logic                       clr_overflow,
   output logic                       m_valid,
   output byte_t                      m_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic          done_sync;
   logic          done_rise;
   logic          done_fall;
   logic          armed;
   logic          push_req;
   logic          push_ok;
   logic          pop;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   byte_t         mem [DEPTH];

   uart_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_100MHz (clk_100MHz),
      .rst        (rst),
      .level      (rx_done),
      .sync       (done_sync),
      .rise       (done_rise),
      .fall       (done_fall)
   );

   // The receiver's first rx_done after reset marks entry to IDLE, so only rises after a fall carry bytes.
   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) armed <= 1'b0;
      else if (done_fall) armed <= 1'b1;
   end

   // A push needs an armed path and a fresh high level; a full FIFO only accepts it alongside a pop.
   assign push_req = armed & done_sync & done_rise;
   assign pop      = m_valid & m_ready;
   assign push_ok  = push_req & (~full | pop);

   // Storage has no reset; the read mux below hides stale contents while empty.
   always_ff @(posedge clk_100MHz) begin
      if (push_ok) mem[wr_ptr] <= rx_data;
   end

   // Pointers wrap naturally at DEPTH; occupancy is tracked explicitly for full/empty.
   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) overflow <= 1'b0;
      else if (push_req & full & ~pop) overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
   end

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign m_valid = ~empty;
   assign m_data  = empty ? 8'h00 : mem[rd_ptr];

endmodule
